// File: rtl/l2_write_buffer_pkg.sv
// Shared types and constants for the L2 posted-write buffer.
package l2_write_buffer_pkg;

  localparam int LC3B_LINE_OFFSET_BITS = 4;

  typedef logic [127:0] lc3b_cache_line;
  typedef logic [15:0]  lc3b_word;
  typedef logic [15-LC3B_LINE_OFFSET_BITS:0] lc3b_wb_line_addr;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    MREAD = 2'd2,
    RESP  = 2'd3
  } lc3b_wb_state;

  // Clears the byte-offset bits so memory always sees a line-aligned address.
  function automatic lc3b_word line_base(input lc3b_word addr);
    return addr & ~((16'd1 << LC3B_LINE_OFFSET_BITS) - 16'd1);
  endfunction

endpackage

// File: rtl/l2_write_buffer_if.sv
// L2-side and memory-side handshake bundle; the buffer is the slave, the
// environment (L2 + physical memory) is the master.
interface l2_write_buffer_if;
  import l2_write_buffer_pkg::*;

  lc3b_word       l2_address;
  lc3b_cache_line l2_wdata;
  logic           l2_read;
  logic           l2_write;
  lc3b_cache_line l2_rdata;
  logic           l2_resp;
  lc3b_word       pmem_address;
  lc3b_cache_line pmem_wdata;
  logic           pmem_read;
  logic           pmem_write;
  lc3b_cache_line pmem_rdata;
  logic           pmem_resp;

  modport slave (
    input  l2_address, l2_wdata, l2_read, l2_write, pmem_rdata, pmem_resp,
    output l2_rdata, l2_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
  );

  modport master (
    output l2_address, l2_wdata, l2_read, l2_write, pmem_rdata, pmem_resp,
    input  l2_rdata, l2_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_write_buffer_array.sv
// Circular line buffer: entry storage, head/tail/count, address match and
// newest-match select. hit_data exists only when L2WB_READ_FORWARD_EN is defined.
module l2_write_buffer_array
  import l2_write_buffer_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  lc3b_wb_line_addr lookup_addr,
  input  logic             head_locked,
  input  logic             push_en,
  input  logic             coal_en,
  input  logic             pop_en,
  input  lc3b_cache_line   wr_data,
  output logic             hit,
`ifdef L2WB_READ_FORWARD_EN
  output lc3b_cache_line   hit_data,
`endif
  output logic             coal_hit,
  output lc3b_wb_line_addr head_addr,
  output lc3b_cache_line   head_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  lc3b_wb_line_addr addr_q [DEPTH];
  lc3b_wb_line_addr addr_d [DEPTH];
  lc3b_cache_line   data_q [DEPTH];
  lc3b_cache_line   data_d [DEPTH];
  ptr_t             head_q, head_d, tail_q, tail_d, coal_idx_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] match_s;

  // Per-entry address compare
  always_comb begin
    match_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_q[i] && (addr_q[i] == lookup_addr);
    end
  end

  // Walk oldest to newest so the last match seen is the newest; a draining head is skipped for coalescing
  always_comb begin
    ptr_t idx;
    hit        = 1'b0;
    coal_hit   = 1'b0;
    coal_idx_s = head_q;
`ifdef L2WB_READ_FORWARD_EN
    hit_data   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + ptr_t'(k);
      if (match_s[idx]) begin
        hit = 1'b1;
`ifdef L2WB_READ_FORWARD_EN
        hit_data = data_q[idx];
`endif
        if (!(head_locked && (k == 0))) begin
          coal_hit   = 1'b1;
          coal_idx_s = idx;
        end else begin
          coal_hit   = coal_hit;
        end
      end else begin
        hit = hit;
      end
    end
  end

  // Next-state for push, coalesce and pop
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_en) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ptr_t'(1);
      count_d         = count_d - CNT_W'(1);
    end else begin
      head_d          = head_q;
    end
    if (coal_en) begin
      data_d[coal_idx_s] = wr_data;
    end else if (push_en) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = lookup_addr;
      data_d[tail_q]  = wr_data;
      tail_d          = tail_q + ptr_t'(1);
      count_d         = count_d + CNT_W'(1);
    end else begin
      tail_d          = tail_q;
    end
  end

  // Entry storage and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/l2_write_buffer.sv
// Posted-write buffer between L2 and physical memory: FSM plus registered L2/pmem outputs.
// Read forwarding from buffered lines is enabled by defining L2WB_READ_FORWARD_EN.
module l2_write_buffer
  import l2_write_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  l2_write_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  lc3b_wb_state     state_q, state_d;
  logic             l2_resp_q, l2_resp_d;
  lc3b_cache_line   l2_rdata_q, l2_rdata_d;
  logic             pmem_read_q, pmem_read_d;
  logic             pmem_write_q, pmem_write_d;
  lc3b_word         pmem_address_q, pmem_address_d;
  lc3b_cache_line   pmem_wdata_q, pmem_wdata_d;

  logic             push_en_s, coal_en_s, pop_en_s;
  logic             hit_s, coal_hit_s, full_s;
  logic             start_drain_s, start_mread_s;
  lc3b_wb_line_addr lookup_addr_s, head_addr_s;
  lc3b_cache_line   head_data_s;
  logic [CNT_W-1:0] count_s;
`ifdef L2WB_READ_FORWARD_EN
  lc3b_cache_line   hit_data_s;
`endif

  assign lookup_addr_s = bus.l2_address[15:LC3B_LINE_OFFSET_BITS];

  l2_write_buffer_array #(.DEPTH(DEPTH)) u_array (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (lookup_addr_s),
    .head_locked (state_q == DRAIN),
    .push_en     (push_en_s),
    .coal_en     (coal_en_s),
    .pop_en      (pop_en_s),
    .wr_data     (bus.l2_wdata),
    .hit         (hit_s),
`ifdef L2WB_READ_FORWARD_EN
    .hit_data    (hit_data_s),
`endif
    .coal_hit    (coal_hit_s),
    .head_addr   (head_addr_s),
    .head_data   (head_data_s),
    .count       (count_s),
    .full        (full_s)
  );

  // Next-state and output decode; IDLE priority is read, then write, then drain
  always_comb begin
    state_d        = state_q;
    l2_resp_d      = 1'b0;
    l2_rdata_d     = l2_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    push_en_s      = 1'b0;
    coal_en_s      = 1'b0;
    pop_en_s       = 1'b0;
    start_drain_s  = 1'b0;
    start_mread_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.l2_read) begin
`ifdef L2WB_READ_FORWARD_EN
          if (hit_s) begin
            state_d    = RESP;
            l2_resp_d  = 1'b1;
            l2_rdata_d = hit_data_s;
          end else begin
            start_mread_s = 1'b1;
          end
`else
          // Stale line in the buffer: flush it to memory before reading
          if (hit_s) begin
            start_drain_s = 1'b1;
          end else begin
            start_mread_s = 1'b1;
          end
`endif
        end else if (bus.l2_write) begin
          if (coal_hit_s) begin
            coal_en_s = 1'b1;
            state_d   = RESP;
            l2_resp_d = 1'b1;
          end else if (!full_s) begin
            push_en_s = 1'b1;
            state_d   = RESP;
            l2_resp_d = 1'b1;
          end else begin
            start_drain_s = 1'b1;
          end
        end else if (count_s != '0) begin
          start_drain_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (bus.pmem_resp) begin
          pop_en_s     = 1'b1;
          pmem_write_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d      = DRAIN;
        end
      end
      MREAD: begin
        if (bus.pmem_resp) begin
          pmem_read_d = 1'b0;
          l2_rdata_d  = bus.pmem_rdata;
          l2_resp_d   = 1'b1;
          state_d     = RESP;
        end else begin
          state_d     = MREAD;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_drain_s) begin
      state_d        = DRAIN;
      pmem_write_d   = 1'b1;
      pmem_address_d = {head_addr_s, {LC3B_LINE_OFFSET_BITS{1'b0}}};
      pmem_wdata_d   = head_data_s;
    end else if (start_mread_s) begin
      state_d        = MREAD;
      pmem_read_d    = 1'b1;
      pmem_address_d = line_base(bus.l2_address);
    end else begin
      pmem_wdata_d   = pmem_wdata_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      l2_resp_q      <= 1'b0;
      l2_rdata_q     <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      l2_resp_q      <= l2_resp_d;
      l2_rdata_q     <= l2_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign bus.l2_resp      = l2_resp_q;
  assign bus.l2_rdata     = l2_rdata_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

endmodule

// File: doc/l2_write_buffer.md
# l2_write_buffer

Posted-write buffer between the L2 cache's physical-memory port and physical memory. Dirty-line evictions from L2 complete in one cycle into a small line buffer and drain to memory in the background. L2 line fills are served from memory, or from a buffered line when the address matches. Transparent to L2: it sees the same read/write/resp handshake it would see from memory.

## Interface
- DEPTH, 2: buffer entries, power of two, 2..8.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- l2_address  in  16  line address from L2; bits [3:0] ignored.
- l2_wdata  in  128  line to write (lc3b_cache_line).
- l2_read  in  1  line fill request, held until l2_resp.
- l2_write  in  1  line writeback request, held until l2_resp.
- l2_rdata  out  128  fill data, valid while l2_resp high.
- l2_resp  out  1  one-cycle completion pulse.
- pmem_address  out  16  line address to memory, bits [3:0] zero.
- pmem_wdata  out  128  line to memory.
- pmem_read  out  1  memory read, held until pmem_resp.
- pmem_write  out  1  memory write, held until pmem_resp.
- pmem_rdata  in  128  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.

## Operation
- Storage: DEPTH entries {valid, line_addr[15:4], data[127:0]}, circular FIFO with head/tail pointers and a count of width log2(DEPTH)+1.
- Match: an entry matches when it is valid and its line_addr equals l2_address[15:4].
- Write accept, evaluated in IDLE:
  - If a non-draining entry matches, overwrite its data in place (coalesce).
  - Else, if count < DEPTH, push at tail.
  - Else, stall.
  - On accept, l2_resp is asserted the next cycle.
- Read:
  - If a match exists, the newest matching entry's data is returned (see Configuration).
  - Otherwise issue pmem_read with address l2_address & 16'hFFF0.
  - Latch pmem_rdata on pmem_resp and return it with l2_resp the next cycle.
- Drain: in IDLE, with count > 0 and no serviceable L2 request pending, drive pmem_write with the head entry. On pmem_resp, pop the head.
- Priority in IDLE, highest first: (1) L2 read, (2) L2 write, (3) drain.
- FSM states: IDLE, DRAIN, MREAD, RESP.
  - IDLE→RESP: accepted write or forwarded read.
  - IDLE→MREAD: unmatched read.
  - IDLE→DRAIN: drain start.
  - MREAD→RESP on pmem_resp.
  - DRAIN→IDLE on pmem_resp.
  - RESP→IDLE unconditionally.
- The head entry in DRAIN is locked. A write matching it allocates a new entry, or stalls if the buffer is full; it never modifies pmem_wdata mid-transaction.
- Full and writing: the write stalls until the current drain pops. It is accepted at the earliest in the IDLE cycle after the pop; no same-cycle push/pop.
- Reset, including mid-transaction: all valid bits 0, pointers and count 0, FSM IDLE. Buffered lines are discarded.

## Timing
- Reset values: l2_resp 0, l2_rdata 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0.
- All outputs are registered or decoded from state only; there is no combinational path from L2 inputs to pmem outputs.
- Write hit, not full: request at cycle N → l2_resp at N+1.
- Forwarded read: request at N → l2_resp with data at N+1.
- Memory read: pmem_read from N+1 until pmem_resp at cycle M → l2_resp at M+1.
- A read arriving during DRAIN waits for the drain's pmem_resp, then is serviced from IDLE.
- In RESP the block ignores l2_read and l2_write; L2 must drop or change its request by the following cycle.
- pmem_read and pmem_write are never high together. pmem_address and pmem_wdata are stable while either is high.

## Configuration
- L2WB_READ_FORWARD_EN defined: a matching read returns the buffered line as described.
- Not defined: a matching read stalls in IDLE, and draining has priority until no entry matches. The read then goes to memory. The forwarding mux is absent.

## Structure
- lc3b_types gains:
  - lc3b_wb_line_addr (12-bit line address).
  - lc3b_wb_state enum {IDLE, DRAIN, MREAD, RESP}.
  - Constant LC3B_LINE_OFFSET_BITS = 4.
- One sub-module, l2_write_buffer_array:
  - Entry registers, pointers and count.
  - Match vector, newest-match select.
  - Push, coalesce and pop ports.
- Top level holds the FSM and the pmem/L2 output registers.

## Test plan
- Reset with stale stimulus: rst during DRAIN with pmem_write high → pmem_write 0 immediately; count 0; a subsequent read of 16'h1230 goes to memory.
- Posted write: write 16'h1230 data A → l2_resp at N+1; pmem_write later drives 16'h1230 with A; pop on pmem_resp, count 0.
- Coalesce: write 16'h4000 A, then 16'h4008 B before drain → one entry; the single memory write carries data B to 16'h4000.
- Full stall: DEPTH=2, writes to 16'h1000, 16'h2000, 16'h3000 with pmem_resp delayed 10 cycles → third write gets l2_resp only after the first drain pops; memory receives the three lines in order.
- Forward vs. no-forward: buffer holds 16'h5550 = C, then read 16'h5550. With L2WB_READ_FORWARD_EN: l2_rdata = C at N+1 and no pmem_read. Without it: pmem_write of C first, then pmem_read, and l2_rdata equals memory's contents.
- Unmatched read during drain: drain in flight, read 16'h7770 → pmem_read is asserted only after the drain's pmem_resp; l2_resp arrives one cycle after the read's pmem_resp.
